// File: rtl/byte_word_assembler.sv
// byte_word_assembler: reassembles an LSB-first byte stream into 32-bit words behind a valid/ready output register.
//
// Ports:
//   CLK_0      in   1   clock, all state updates on the rising edge
//   RST_N      in   1   asynchronous active-low reset
//   data_in    in   8   incoming byte
//   in_valid   in   1   data_in carries a byte this cycle
//   sof        in   1   start-of-word marker (used only with BWA_SOF_RESYNC_EN)
//   in_ready   out  1   byte is accepted this cycle (combinational)
//   data_out   out  32  assembled word, byte 0 in [7:0]
//   out_valid  out  1   data_out holds an unconsumed word
//   out_ready  in   1   consumer takes data_out this cycle
//   ovf        out  1   sticky: a byte was dropped because the fourth lane stalled
//   sync_err   out  1   one-cycle pulse: sof arrived mid-word
//
// Optional feature: define BWA_SOF_RESYNC_EN to let sof force the byte into lane 0.
// Without it sof is ignored and sync_err stays 0.
module byte_word_assembler (
    input  logic        CLK_0,
    input  logic        RST_N,
    input  logic [7:0]  data_in,
    input  logic        in_valid,
    input  logic        sof,
    output logic        in_ready,
    output logic [31:0] data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ovf,
    output logic        sync_err
);
    logic [1:0]  cnt, cnt_n;
    logic [23:0] part, part_n;
    logic [31:0] data_out_n;
    logic        out_valid_n, ovf_n, sync_err_n;
    logic        accept, sof_hit, wr, complete;

    // Only the completing byte can stall; lanes 0..2 always have room in part.
    assign in_ready = !(cnt == 2'd3 && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

`ifdef BWA_SOF_RESYNC_EN
    assign sof_hit = accept && sof;
`else
    logic sof_unused;
    assign sof_unused = sof;
    assign sof_hit    = 1'b0;
`endif

    // A sof byte restarts the word, so it never completes one even at cnt==3.
    assign wr       = accept && !sof_hit;
    assign complete = wr && cnt == 2'd3;

    always_comb begin
        cnt_n         = sof_hit ? 2'd1 : accept ? cnt + 2'd1 : cnt;
        part_n[7:0]   = (sof_hit || (wr && cnt == 2'd0)) ? data_in : part[7:0];
        part_n[15:8]  = sof_hit ? 8'h00 : (wr && cnt == 2'd1) ? data_in : part[15:8];
        part_n[23:16] = sof_hit ? 8'h00 : (wr && cnt == 2'd2) ? data_in : part[23:16];
        data_out_n    = complete ? {data_in, part} : data_out;
        out_valid_n   = complete || (out_valid && !out_ready);
        ovf_n         = ovf || (in_valid && !in_ready);
        sync_err_n    = sof_hit && cnt != 2'd0;
    end

    always_ff @(posedge CLK_0 or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= 2'd0;
            part      <= 24'h0;
            data_out  <= 32'h0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            part      <= part_n;
            data_out  <= data_out_n;
            out_valid <= out_valid_n;
            ovf       <= ovf_n;
            sync_err  <= sync_err_n;
        end
    end
endmodule

// File: tb/tb_byte_word_assembler.sv
// tb_byte_word_assembler: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_byte_word_assembler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        in_valid, sof, in_ready, out_valid, out_ready, ovf, sync_err;
    logic [31:0] data_out;
    logic [31:0] exp_q[$];
    int          vectors = 0;
    int          errors = 0;

    byte_word_assembler dut (
        .CLK_0(clk), .RST_N(rst_n), .data_in(data_in), .in_valid(in_valid), .sof(sof),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input logic s);
        data_in  = b;
        sof      = s;
        in_valid = 1'b1;
        @(posedge clk) #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    // Monitor: a transfer is pending whenever out_valid && out_ready in the stable half of the cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_word: got %h, expected none", data_out);
            end else begin
                chk("word", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; data_in = 8'h00; in_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        chk("rst_sync_err", {31'h0, sync_err}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk) #1;

        // Basic word
        exp_q.push_back(32'h12345678);
        put(8'h78, 0); put(8'h56, 0); put(8'h34, 0); put(8'h12, 0);
        chk("t1_out_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_ovf", {31'h0, ovf}, 32'h0);
        @(posedge clk) #1;
        chk("t1_valid_drop", {31'h0, out_valid}, 32'h0);

        // Back-to-back words at full rate
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        for (int i = 1; i <= 8; i++) put(i[7:0], 0);
        @(posedge clk) #1;

        // Backpressure: fourth byte of second word stalls and is dropped
        out_ready = 1'b0;
        exp_q.push_back(32'h14131211);
        put(8'h11, 0); put(8'h12, 0); put(8'h13, 0); put(8'h14, 0);
        put(8'h15, 0); put(8'h16, 0); put(8'h17, 0);
        chk("t3_held", data_out, 32'h14131211);
        data_in = 8'h18; in_valid = 1'b1;
        #1;
        chk("t3_in_ready_low", {31'h0, in_ready}, 32'h0);
        @(posedge clk) #1;
        chk("t3_ovf", {31'h0, ovf}, 32'h1);
        chk("t3_still_held", data_out, 32'h14131211);
        // Re-offer with the consumer ready: completion and transfer in the same edge
        exp_q.push_back(32'h18171615);
        out_ready = 1'b1;
        #1;
        chk("t3_in_ready_high", {31'h0, in_ready}, 32'h1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        chk("t4_no_gap_valid", {31'h0, out_valid}, 32'h1);
        chk("t4_new_word", data_out, 32'h18171615);
        @(posedge clk) #1;
        chk("t4_ovf_sticky", {31'h0, ovf}, 32'h1);

        // sof resync (or its absence)
`ifdef BWA_SOF_RESYNC_EN
        exp_q.push_back(32'h04030201);
`else
        exp_q.push_back(32'h0201BBAA);
`endif
        put(8'hAA, 0); put(8'hBB, 0); put(8'h01, 1);
`ifdef BWA_SOF_RESYNC_EN
        chk("t5_sync_err_pulse", {31'h0, sync_err}, 32'h1);
`else
        chk("t5_sync_err_zero", {31'h0, sync_err}, 32'h0);
`endif
        put(8'h02, 0);
        chk("t5_sync_err_clear", {31'h0, sync_err}, 32'h0);
        put(8'h03, 0); put(8'h04, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-word, then a clean word
        put(8'h99, 0); put(8'h98, 0);
        rst_n = 1'b0;
        #2;
        chk("t6_rst_ovf", {31'h0, ovf}, 32'h0);
        chk("t6_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("t6_rst_data", data_out, 32'h0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        @(posedge clk) #1;
        exp_q.push_back(32'h11223344);
        put(8'h44, 0); put(8'h33, 0); put(8'h22, 0); put(8'h11, 0);
        chk("t6_word", data_out, 32'h11223344);
        chk("t6_ovf", {31'h0, ovf}, 32'h0);
        chk("t6_sync_err", {31'h0, sync_err}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
